// File: rtl/elevator_move.sv
// Two-car motion sequencer: each car steps floor by floor under turn/hold verdicts
// from the upstream decision stage and reports its floor, direction and door state.

module elevator_car #(
    parameter int FLOORS      = 7,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_turn,
    input  logic       i_hold,
    output logic [2:0] o_floor,
    output logic       o_dir,
    output logic       o_doorOpen,
    output logic       o_moving,
    output logic       o_arrive
);
    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    TOP_FLOOR = 3'(FLOORS);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, DOOR} state_t;

    state_t        r_state, w_stateNext;
    logic [2:0]    r_floor, w_floorNext;
    logic          r_dir, w_dirNext;
    logic [TW-1:0] r_tmr, w_tmrNext;
    logic          w_atBoundary;

    assign w_atBoundary = (r_dir && (r_floor == TOP_FLOOR)) ||
                          (!r_dir && (r_floor == 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_floor <= 3'd1;
            r_dir   <= 1'b1;
            r_tmr   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_floor <= w_floorNext;
            r_dir   <= w_dirNext;
            r_tmr   <= w_tmrNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_floorNext = r_floor;
        w_dirNext   = r_dir;
        w_tmrNext   = r_tmr;
        case (r_state)
            IDLE: begin
                if (i_hold) begin
                    w_stateNext = DOOR;
                    w_tmrNext   = DOOR_LOAD;
                end else if (!i_turn && !w_atBoundary) begin
                    w_stateNext = MOVE;
                    w_tmrNext   = MOVE_LOAD;
                end else begin
                    w_dirNext = ~r_dir;
                end
            end
            MOVE: begin
                if (r_tmr == '0) begin
                    w_floorNext = r_dir ? (r_floor + 3'd1) : (r_floor - 3'd1);
                    w_stateNext = CHECK;
                end else begin
                    w_tmrNext = r_tmr - 1'b1;
                end
            end
            CHECK: begin
                // The floor register already holds the new floor, so the boundary test sees it.
                if (i_hold) begin
                    w_stateNext = DOOR;
                    w_tmrNext   = DOOR_LOAD;
                end else if (i_turn || w_atBoundary) begin
                    w_dirNext   = ~r_dir;
                    w_stateNext = IDLE;
                end else begin
                    w_stateNext = MOVE;
                    w_tmrNext   = MOVE_LOAD;
                end
            end
            DOOR: begin
                if (r_tmr == '0) begin
                    w_stateNext = IDLE;
                end else begin
                    w_tmrNext = r_tmr - 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign o_floor    = r_floor;
    assign o_dir      = r_dir;
    assign o_doorOpen = (r_state == DOOR);
    assign o_moving   = (r_state == MOVE);
    assign o_arrive   = (r_state == CHECK);
endmodule

module elevator_move #(
    parameter int FLOORS      = 7,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] turn,
    input  logic       hold_1,
    input  logic       hold_2,
    output logic [2:0] curr_elevator_1,
    output logic [2:0] curr_elevator_2,
    output logic [1:0] dir_elevator,
    output logic [1:0] door_open,
    output logic [1:0] moving,
    output logic [1:0] arrive
);
    // Bit 1 of every paired signal belongs to car 1, bit 0 to car 2.
    elevator_car #(
        .FLOORS(FLOORS), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
    ) u_car1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_turn     (turn[1]),
        .i_hold     (hold_1),
        .o_floor    (curr_elevator_1),
        .o_dir      (dir_elevator[1]),
        .o_doorOpen (door_open[1]),
        .o_moving   (moving[1]),
        .o_arrive   (arrive[1])
    );

    elevator_car #(
        .FLOORS(FLOORS), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
    ) u_car2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_turn     (turn[0]),
        .i_hold     (hold_2),
        .o_floor    (curr_elevator_2),
        .o_dir      (dir_elevator[0]),
        .o_doorOpen (door_open[0]),
        .o_moving   (moving[0]),
        .o_arrive   (arrive[0])
    );
endmodule
